// File: rtl/sn_read_responder.sv
// CHI subordinate-node read responder: queues ReadNoSnp requests and returns each
// 16-byte line as two CompData beats after a fixed memory access latency.
module sn_read_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 4,
  parameter int IDX_W      = 10
) (
  input  logic             i_clock,
  input  logic             i_reset,
  // Request flit, LSB first: TgtID[6:0] SrcID[13:7] TxnID[21:14] Opcode[27:22]
  // Addr[75:28] Size[78:76] ReturnTxnID[86:79] StashNID_ReturnNID[93:87]
  input  logic [93:0]      i_req,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  output logic [6:0]       o_dat_tgtid,
  output logic [6:0]       o_dat_homenid,
  output logic [7:0]       o_dat_txnid,
  output logic [7:0]       o_dat_dbid,
  output logic [5:0]       o_dat_opcode,
  output logic [2:0]       o_dat_resp,
  output logic             o_dat_dataid,
  output logic [63:0]      o_dat_data,
  output logic             o_dat_valid,
  input  logic             i_dat_ready,
  input  logic             i_mem_wr_en,
  input  logic [IDX_W-1:0] i_mem_wr_idx,
  input  logic [127:0]     i_mem_wr_data,
  output logic             o_err_unsupported
);
  localparam logic [5:0] OP_READNOSNP = 6'h04;
  localparam int ENT_W = IDX_W + 30;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT0, S_BEAT1} state_t;
  state_t r_state, w_state_next;

  logic [ENT_W-1:0] r_fifo [FIFO_DEPTH];
  logic [127:0]     r_mem [2**IDX_W];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [ENT_W-1:0] r_cur;
  logic [127:0]     r_line;
  logic             r_err;
  logic             w_accept, w_push, w_pop, w_capture;
  logic [ENT_W-1:0] w_entry;
  logic             w_unused;

  // Entry: {line index, ReturnNID, ReturnTxnID, SrcID, TxnID}
  assign w_entry  = {i_req[32 +: IDX_W], i_req[93:87], i_req[86:79], i_req[13:7], i_req[21:14]};
  assign w_unused = &{1'b0, i_req};

  assign o_req_ready       = (r_count != FULL_COUNT);
  assign w_accept          = i_req_valid & o_req_ready;
  assign w_push            = w_accept & (i_req[27:22] == OP_READNOSNP);
  assign o_err_unsupported = r_err;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_capture     = 1'b0;
    o_dat_valid   = 1'b0;
    o_dat_tgtid   = '0;
    o_dat_homenid = '0;
    o_dat_txnid   = '0;
    o_dat_dbid    = '0;
    o_dat_opcode  = '0;
    o_dat_resp    = '0;
    o_dat_dataid  = 1'b0;
    o_dat_data    = '0;
    case (r_state)
      S_IDLE:  if (r_count != '0) begin
                 w_pop        = 1'b1;
                 w_state_next = S_WAIT;
               end
      S_WAIT:  if (r_lat_cnt == LAT_LAST) begin
                 w_capture    = 1'b1;
                 w_state_next = S_BEAT0;
               end
      S_BEAT0: if (i_dat_ready) w_state_next = S_BEAT1;
      S_BEAT1: if (i_dat_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (r_state == S_BEAT0 || r_state == S_BEAT1) begin
      o_dat_valid   = 1'b1;
      o_dat_tgtid   = r_cur[29:23];
      o_dat_txnid   = r_cur[22:15];
      o_dat_homenid = r_cur[14:8];
      o_dat_dbid    = r_cur[7:0];
      o_dat_opcode  = 6'h04;
      o_dat_resp    = 3'b010;
      o_dat_dataid  = (r_state == S_BEAT1);
      o_dat_data    = (r_state == S_BEAT1) ? r_line[127:64] : r_line[63:0];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_lat_cnt <= '0;
      r_cur     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_cur    <= r_fifo[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)
        r_lat_cnt <= '0;
      else if (r_state == S_WAIT)
        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
    end
  end

  // Storage is never reset; a write on the capture edge is not seen by the read.
  always_ff @(posedge i_clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_entry;
    if (i_mem_wr_en) r_mem[i_mem_wr_idx] <= i_mem_wr_data;
    if (w_capture) r_line <= r_mem[r_cur[ENT_W-1:30]];
  end

endmodule

// File: tb/tb_sn_read_responder.sv
// Randomized bench for sn_read_responder: an ordered request queue plus a line
// memory image predict every CompData beat.
`timescale 1ns/1ps
module tb_sn_read_responder;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 4;
  localparam int IDX_W      = 10;
  localparam logic [5:0] OP_RNS = 6'h04;
  localparam logic [5:0] OP_RU  = 6'h07;

  typedef struct packed {
    logic [6:0]  tgtid;
    logic [6:0]  homenid;
    logic [7:0]  txnid;
    logic [7:0]  dbid;
    logic [5:0]  opcode;
    logic [2:0]  resp;
    logic        dataid;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [93:0] req;
  logic req_valid, req_ready;
  logic [6:0] dat_tgtid, dat_homenid;
  logic [7:0] dat_txnid, dat_dbid;
  logic [5:0] dat_opcode;
  logic [2:0] dat_resp;
  logic dat_dataid;
  logic [63:0] dat_data;
  logic dat_valid, dat_ready;
  logic mem_wr_en;
  logic [IDX_W-1:0] mem_wr_idx;
  logic [127:0] mem_wr_data;
  logic err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_changes = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  int seen_q[$];
  logic [127:0] mdl_mem [0:(1<<IDX_W)-1];

  sn_read_responder #(.FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT), .IDX_W(IDX_W)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .o_dat_tgtid(dat_tgtid), .o_dat_homenid(dat_homenid), .o_dat_txnid(dat_txnid),
    .o_dat_dbid(dat_dbid), .o_dat_opcode(dat_opcode), .o_dat_resp(dat_resp),
    .o_dat_dataid(dat_dataid), .o_dat_data(dat_data), .o_dat_valid(dat_valid),
    .i_dat_ready(dat_ready), .i_mem_wr_en(mem_wr_en), .i_mem_wr_idx(mem_wr_idx),
    .i_mem_wr_data(mem_wr_data), .o_err_unsupported(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [93:0] make_flit(input logic [5:0] op, input logic [47:0] addr,
      input logic [6:0] rnid, input logic [7:0] rtxn, input logic [6:0] srcid, input logic [7:0] txnid);
    return {rnid, rtxn, 3'($urandom), addr, op, txnid, srcid, 7'($urandom)};
  endfunction

  function automatic beat_t sample_beat();
    return '{dat_tgtid, dat_homenid, dat_txnid, dat_dbid, dat_opcode, dat_resp, dat_dataid, dat_data};
  endfunction

  // Model: a served request yields two beats built from the line held at acceptance.
  task automatic expect_read(input logic [IDX_W-1:0] idx, input logic [6:0] rnid,
      input logic [7:0] rtxn, input logic [6:0] srcid, input logic [7:0] txnid);
    beat_t b;
    b = '{rnid, srcid, rtxn, txnid, 6'h04, 3'b010, 1'b0, mdl_mem[idx][63:0]};
    exp_q.push_back(b);
    b.dataid = 1'b1;
    b.data   = mdl_mem[idx][127:64];
    exp_q.push_back(b);
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [127:0] d);
    mem_wr_en = 1'b1; mem_wr_idx = idx; mem_wr_data = d;
    @(negedge clk);
    mem_wr_en = 1'b0;
    mdl_mem[idx] = d;
  endtask

  // Leaves req_valid high; acc is the edge count just after the accepting edge.
  task automatic drive_req(input logic [93:0] f, output bit ok, output int acc);
    ok = 1'b0; acc = 0;
    req = f; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        @(negedge clk);
        ok = 1'b1; acc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_random(input logic [IDX_W-1:0] idx, output bit ok);
    logic [47:0] a;
    logic [6:0] rnid, srcid;
    logic [7:0] rtxn, txnid;
    int acc;
    a = 48'({$urandom(), $urandom()});
    a[4 +: IDX_W] = idx;
    rnid = 7'($urandom); srcid = 7'($urandom); rtxn = 8'($urandom); txnid = 8'($urandom);
    drive_req(make_flit(OP_RNS, a, rnid, rtxn, srcid, txnid), ok, acc);
    if (ok) expect_read(idx, rnid, rtxn, srcid, txnid);
  endtask

  // Records handshaken beats and counts any change of a stalled beat.
  task automatic collect_beats(input int n, input bit rand_ready, output bit ok);
    beat_t cur, held;
    bit held_v;
    int got, first_seen;
    got = 0; held_v = 1'b0; first_seen = 0; held = '0;
    for (int g = 0; g < 2000 && got < n; g++) begin
      if (dat_valid) begin
        cur = sample_beat();
        if (!held_v) first_seen = cyc;
        else if (cur !== held) stall_changes++;
        dat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dat_ready) begin
          obs_q.push_back(cur); seen_q.push_back(first_seen); got++; held_v = 1'b0;
          $display("beat: tgt=%0d txn=%h dbid=%h dataid=%0d data=%h @%0d",
                   cur.tgtid, cur.txnid, cur.dbid, cur.dataid, cur.data, first_seen);
        end else begin
          held = cur; held_v = 1'b1;
        end
      end else begin
        if (held_v) stall_changes++;
        held_v = 1'b0;
        dat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
    end
    dat_ready = 1'b0;
    ok = (got == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", req_ready); end
    n_cmp++; if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", dat_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
    n_cmp++; if (sample_beat() !== '0) begin n_fail++; $display("FAIL reset_fields: got %h, expected 0", sample_beat()); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_ready, dat_valid} !== 2'b10) begin n_fail++; $display("FAIL post_reset: got ready/valid %b, expected 10", {req_ready, dat_valid}); end
  endtask

  task automatic test_basic();
    bit ok;
    int acc;
    beat_t b0, b1;
    preload(10'd5, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
    obs_q.delete(); seen_q.delete();
    dat_ready = 1'b1;
    drive_req(make_flit(OP_RNS, 48'h50, 7'd3, 8'h12, 7'd9, 8'h33), ok, acc);
    req_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b, expected 1", ok); end
    collect_beats(2, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_beats: got %0d beats, expected 2", obs_q.size()); end
    b0 = (obs_q.size() > 0) ? obs_q[0] : '0;
    b1 = (obs_q.size() > 1) ? obs_q[1] : '0;
    n_cmp++; if (b0 !== '{7'd3, 7'd9, 8'h12, 8'h33, 6'h04, 3'b010, 1'b0, 64'h2222_2222_2222_2222}) begin
      n_fail++; $display("FAIL basic_beat0: got %h", b0); end
    n_cmp++; if (b1 !== '{7'd3, 7'd9, 8'h12, 8'h33, 6'h04, 3'b010, 1'b1, 64'h1111_1111_1111_1111}) begin
      n_fail++; $display("FAIL basic_beat1: got %h", b1); end
    n_cmp++; if ((seen_q.size() > 0 ? seen_q[0] : -1) !== acc + RD_LAT + 1) begin
      n_fail++; $display("FAIL basic_latency: got cycle %0d, expected %0d", seen_q.size() > 0 ? seen_q[0] : -1, acc + RD_LAT + 1); end
    n_cmp++; if ((seen_q.size() > 1 ? seen_q[1] : -1) !== acc + RD_LAT + 2) begin
      n_fail++; $display("FAIL basic_beat1_cycle: got %0d, expected %0d", seen_q.size() > 1 ? seen_q[1] : -1, acc + RD_LAT + 2); end
  endtask

  task automatic test_unsupported();
    bit ok;
    int acc, nv;
    dat_ready = 1'b1;
    drive_req(make_flit(OP_RU, 48'($urandom), 7'd1, 8'h44, 7'd2, 8'h55), ok, acc);
    req_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL unsup_accept: got %b, expected 1", ok); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL unsup_pulse: got %b, expected 1", err); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL unsup_pulse_width: got %b, expected 0", err); end
    nv = 0;
    repeat (RD_LAT + 6) begin nv += int'(dat_valid); @(negedge clk); end
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL unsup_no_data: got %0d valid cycles, expected 0", nv); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL unsup_ready: got %b, expected 1", req_ready); end
    dat_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n_acc;
    logic [IDX_W-1:0] idxs [5];
    obs_q.delete(); exp_q.delete(); seen_q.delete();
    for (int i = 0; i < 5; i++) begin
      idxs[i] = IDX_W'(16 + 3 * i);
      preload(idxs[i], {$urandom(), $urandom(), $urandom(), $urandom()});
    end
    dat_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_random(idxs[$urandom_range(0, 4)], ok);
      n_acc += int'(ok);
    end
    req_valid = 1'b0;
    n_cmp++; if (n_acc !== 5) begin n_fail++; $display("FAIL b2b_accepts: got %0d, expected 5", n_acc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got ready %b, expected 0", req_ready); end
    collect_beats(10, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_count: got %0d beats, expected 10", obs_q.size()); end
    for (int i = 0; i < 10 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int nv;
    obs_q.delete(); exp_q.delete(); seen_q.delete();
    stall_changes = 0;
    dat_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_random(IDX_W'(16 + 3 * $urandom_range(0, 4)), ok);
    req_valid = 1'b0;
    collect_beats(8, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_count: got %0d beats, expected 8", obs_q.size()); end
    n_cmp++; if (stall_changes !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes, expected 0", stall_changes); end
    for (int i = 0; i < 8 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]); end
    end
    nv = 0;
    dat_ready = 1'b1;
    repeat (10) begin nv += int'(dat_valid); @(negedge clk); end
    dat_ready = 1'b0;
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL stall_extra_beats: got %0d valid cycles, expected 0", nv); end
  endtask

  task automatic test_mem_write_in_flight();
    bit ok, seen;
    obs_q.delete(); exp_q.delete(); seen_q.delete();
    preload(10'd5, {64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002});
    dat_ready = 1'b0;
    send_random(10'd5, ok);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dat_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wr_beat0_wait: got no valid, expected valid"); end
    preload(10'd5, {64'hCCCC_0000_CCCC_0003, 64'hDDDD_0000_DDDD_0004});
    collect_beats(2, 1'b0, ok);
    send_random(10'd5, ok);
    req_valid = 1'b0;
    collect_beats(2, 1'b0, ok);
    n_cmp++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL wr_count: got %0d beats, expected 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int nv;
    obs_q.delete(); exp_q.delete(); seen_q.delete();
    preload(10'd7, {$urandom(), $urandom(), $urandom(), $urandom()});
    dat_ready = 1'b0;
    send_random(10'd7, ok);
    req_valid = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dat_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait: got no valid, expected valid"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", dat_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, expected 1", req_ready); end
    n_cmp++; if (dat_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_data: got %h, expected 0", dat_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dat_ready = 1'b1;
    nv = 0;
    repeat (RD_LAT + 8) begin nv += int'(dat_valid); @(negedge clk); end
    n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_no_beat: got %0d valid cycles, expected 0", nv); end
    send_random(10'd7, ok);
    req_valid = 1'b0;
    collect_beats(2, 1'b0, ok);
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_mem_beat%0d: got %h, expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_mem_count: got %0d beats, expected 2", obs_q.size()); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_valid = 1'b0; dat_ready = 1'b0;
    mem_wr_en = 1'b0; mem_wr_idx = '0; mem_wr_data = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_unsupported();
    test_back_to_back();
    test_stall();
    test_mem_write_in_flight();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
